// File: rtl/fsm_receiver.sv
// UART receive-path control FSM: start, DATA_BITS data bits, optional parity bit, stop bit.
// The parity bit is built only when FSM_RECEIVER_PARITY_EN is defined.
module fsm_receiver #(
  parameter int DATA_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic parity_error,
  output logic shift,
  output logic parity_load,
  output logic check_stop
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    PARITY = 2'b10,
    STOP   = 2'b11
  } state_t;

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [CNT_W-1:0] bit_cnt_next_s;
  logic             shift_r;

  // Next-state and bit-counter decode
  always_comb begin
    next_state_s   = state_r;
    bit_cnt_next_s = bit_cnt_r;
    case (state_r)
      IDLE: begin
        if (start == 1'b0) begin
          next_state_s   = DATA;
          bit_cnt_next_s = {CNT_W{1'b0}};
        end else begin
          next_state_s   = IDLE;
        end
      end
      DATA: begin
        bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
        if (bit_cnt_r == LAST_BIT) begin
`ifdef FSM_RECEIVER_PARITY_EN
          next_state_s = PARITY;
`else
          next_state_s = STOP;
`endif
        end else begin
          next_state_s = DATA;
        end
      end
`ifdef FSM_RECEIVER_PARITY_EN
      PARITY: begin
        next_state_s = STOP;
      end
`endif
      STOP: begin
        next_state_s = IDLE;
      end
      default: begin
        next_state_s   = IDLE;
        bit_cnt_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and shift-enable registers; reset clears everything at once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= {CNT_W{1'b0}};
      shift_r   <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      bit_cnt_r <= bit_cnt_next_s;
      shift_r   <= (next_state_s == DATA);
    end
  end

  assign shift = shift_r;

`ifdef FSM_RECEIVER_PARITY_EN
  logic parity_load_r;

  // Parity-load strobe registered from the next state so it tracks PARITY exactly
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_load_r <= 1'b0;
    end else begin
      parity_load_r <= (next_state_s == PARITY);
    end
  end

  assign parity_load = parity_load_r;
  assign check_stop  = (state_r == STOP) & ~parity_error;
`else
  logic parity_error_unused_s;

  assign parity_error_unused_s = parity_error;
  assign parity_load           = 1'b0;
  assign check_stop            = (state_r == STOP);
`endif

endmodule

// File: tb/tb_fsm_receiver.sv
// Self-checking bench for fsm_receiver: table-driven frames plus scoreboarded corner sequences.
module tb_fsm_receiver;

`ifdef FSM_RECEIVER_PARITY_EN
  localparam int PAR = 1;
  localparam int DB  = 8;
`else
  localparam int PAR = 0;
  localparam int DB  = 5;
`endif
  localparam int PERIOD = DB + 2 + PAR;

  typedef struct {
    logic       s;
    logic       pe;
    logic [2:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic parity_error;
  logic shift;
  logic parity_load;
  logic check_stop;

  int         checks   = 0;
  int         failures = 0;
  int         m_phase;
  logic       prev_start;
  logic [2:0] sb_q[$];
  vec_t       tbl[$];

  always #5 clk = ~clk;

  fsm_receiver #(.DATA_BITS(DB)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .parity_error(parity_error),
    .shift(shift),
    .parity_load(parity_load),
    .check_stop(check_stop)
  );

  function automatic logic [2:0] model_exp(int ph, logic pe);
    logic sh, pl, cs;
    sh = (ph >= 0) && (ph < DB);
    pl = (PAR == 1) && (ph == DB);
    cs = (ph == DB + PAR) && ((PAR == 1) ? !pe : 1'b1);
    return {sh, pl, cs};
  endfunction

  task automatic check_now(input string name, input logic [2:0] exp);
    checks++;
    if ({shift, parity_load, check_stop} !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got {shift,parity_load,check_stop}=%b expected=%b",
               name, $time, {shift, parity_load, check_stop}, exp);
    end
  endtask

  // One bit-clock cycle: advance the frame-timeline model, drive inputs, check outputs.
  task automatic step(input logic s, input logic pe, input logic use_tbl,
                      input logic [2:0] tbl_exp, input string name);
    logic [2:0] e;
    @(posedge clk);
    if (reset) begin
      m_phase = -1;
    end else if (m_phase < 0) begin
      if (!prev_start) m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase > DB + PAR) m_phase = -1;
    end
    #1;
    start        = s;
    parity_error = pe;
    prev_start   = s;
    e = use_tbl ? tbl_exp : model_exp(m_phase, pe);
    sb_q.push_back(e);
    #3;
    check_now(name, sb_q.pop_front());
  endtask

  task automatic add_row(input logic s, input logic pe, input logic [2:0] exp);
    vec_t v;
    v.s = s; v.pe = pe; v.exp = exp;
    tbl.push_back(v);
  endtask

  initial begin
    int active;
    int multi;
    logic cs_err;

    // Frame A: clean frame, parity good.
    add_row(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < DB; i++) add_row(1'b1, 1'b0, 3'b100);
    if (PAR == 1) add_row(1'b1, 1'b0, 3'b010);
    add_row(1'b1, 1'b0, 3'b001);
    add_row(1'b1, 1'b0, 3'b000);
    // Frame B: noise on start/parity_error during DATA, parity error in STOP.
    cs_err = (PAR == 1) ? 1'b0 : 1'b1;
    add_row(1'b0, 1'b0, 3'b000);
    for (int i = 0; i < DB; i++) add_row(i[0], ~i[0], 3'b100);
    if (PAR == 1) add_row(1'b0, 1'b1, 3'b010);
    add_row(1'b1, 1'b1, {2'b00, cs_err});
    add_row(1'b1, 1'b1, 3'b000);
    add_row(1'b1, 1'b0, 3'b000);

    reset = 1'b1; start = 1'b1; parity_error = 1'b0;
    prev_start = 1'b1; m_phase = -1;
    #2;
    check_now("reset_state", 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;

    step(1'b1, 1'b0, 1'b0, 3'b000, "idle");
    step(1'b1, 1'b1, 1'b0, 3'b000, "idle_pe");

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i].s, tbl[i].pe, 1'b1, tbl[i].exp, $sformatf("table_row%0d", i));

    // Line held low: continuous frames.
    active = 0; multi = 0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step(1'b0, 1'b0, 1'b0, 3'b000, "line_low");
      if ((shift + parity_load + check_stop) == 1) active++;
      if ((shift + parity_load + check_stop) > 1) multi++;
    end
    checks++;
    if (active != 3 * (PERIOD - 1) || multi != 0) begin
      failures++;
      $display("FAIL line_low_activity got active=%0d multi=%0d expected active=%0d multi=0",
               active, multi, 3 * (PERIOD - 1));
    end
    for (int i = 0; i < PERIOD + 1; i++) step(1'b1, 1'b0, 1'b0, 3'b000, "drain");

    // Reset in the middle of DATA with the line still low.
    step(1'b0, 1'b0, 1'b0, 3'b000, "pre_reset_start");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 3'b000, "pre_reset_data");
    @(posedge clk);
    #1 reset = 1'b1;
    #1 check_now("reset_async", 3'b000);
    m_phase = -1;
    step(1'b0, 1'b0, 1'b0, 3'b000, "reset_hold");
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b1; prev_start = 1'b1; m_phase = -1;
    step(1'b1, 1'b0, 1'b0, 3'b000, "post_reset_idle");
    step(1'b0, 1'b0, 1'b0, 3'b000, "post_reset_start");
    for (int i = 0; i < PERIOD; i++) step(1'b1, 1'b1, 1'b0, 3'b000, "post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
